// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Fibonacci LFSR random-number generator.
// Words are produced on demand through a request handshake (req_valid/req_ready)
// and handed out through a response handshake (rand_valid/rand_ready).
// Each delivered word advances the LFSR STEPS times to decorrelate outputs.
// Optional build macro: LFSR_PERIOD_MON_EN enables the period monitor
// (stored seed, step counter and period_wrap pulse).
module lfsr_rng #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int unsigned      OUT_W = 8,
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             seed_zero_err,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic [OUT_W-1:0] rand_data,
  output logic [WIDTH-1:0] state_out,
  output logic             busy,
  output logic             period_wrap,
  output logic [WIDTH-1:0] step_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  // Remaining steps after the one taken in the accept cycle.
  localparam logic [7:0] STEPS_M1 = 8'(STEPS - 1);

  logic [1:0]       fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             zero_err_q, zero_err_d;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_fixed;

  // A zero seed would lock the LFSR at zero forever, so it is replaced by SEED.
  assign lfsr_next  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign seed_fixed = (seed_in == '0) ? SEED : seed_in;

  assign req_ready     = (fsm_q == ST_IDLE) && !seed_load;
  assign rand_valid    = (fsm_q == ST_VALID);
  assign busy          = (fsm_q != ST_IDLE);
  assign rand_data     = lfsr_q[OUT_W-1:0];
  assign state_out     = lfsr_q;
  assign seed_zero_err = zero_err_q;

  // Next-state logic: seed loading overrides everything, otherwise run the handshake FSM.
  always_comb begin
    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    zero_err_d = 1'b0;
    if (seed_load) begin
      fsm_d      = ST_IDLE;
      cnt_d      = 8'd0;
      lfsr_d     = seed_fixed;
      zero_err_d = (seed_in == '0);
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (req_valid) begin
            lfsr_d = lfsr_next;
            if (STEPS == 1) begin
              fsm_d = ST_VALID;
            end else begin
              fsm_d = ST_SHIFT;
              cnt_d = STEPS_M1;
            end
          end
        end
        ST_SHIFT: begin
          lfsr_d = lfsr_next;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            fsm_d = ST_VALID;
          end
        end
        ST_VALID: begin
          if (rand_ready) begin
            fsm_d = ST_IDLE;
          end
        end
        default: begin
          fsm_d = ST_IDLE;
        end
      endcase
    end
  end

  // Core state registers with asynchronous reset to the power-on seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ST_IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= 8'd0;
      zero_err_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      zero_err_q <= zero_err_d;
    end
  end

`ifdef LFSR_PERIOD_MON_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic             wrap_q, wrap_d;
  logic             step_en;

  // Period monitor: count steps since the last seed and flag a return to that seed.
  always_comb begin
    step_en    = !seed_load && (((fsm_q == ST_IDLE) && req_valid) || (fsm_q == ST_SHIFT));
    seed_reg_d = seed_load ? seed_fixed : seed_reg_q;
    step_cnt_d = step_cnt_q;
    wrap_d     = 1'b0;
    if (seed_load) begin
      step_cnt_d = '0;
    end else if (step_en) begin
      if (lfsr_next == seed_reg_q) begin
        step_cnt_d = '0;
        wrap_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + ONE;
      end
    end
  end

  // Period monitor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reg_q <= SEED;
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      seed_reg_q <= seed_reg_d;
      step_cnt_q <= step_cnt_d;
      wrap_q     <= wrap_d;
    end
  end

  assign period_wrap = wrap_q;
  assign step_count  = step_cnt_q;
`else
  assign period_wrap = 1'b0;
  assign step_count  = '0;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed self-checking bench for lfsr_rng.
// Instance u_dut uses default parameters (STEPS=1); u_dut4 uses STEPS=4.
// Period-monitor checks follow the LFSR_PERIOD_MON_EN build macro.
module tb_lfsr_rng;

  logic       clk;
  logic       rst_n;

  logic       seed_load, req_valid, rand_ready;
  logic [7:0] seed_in;
  logic       seed_zero_err, req_ready, rand_valid, busy, period_wrap;
  logic [7:0] rand_data, state_out, step_count;

  logic       seed_load4, req_valid4, rand_ready4;
  logic [7:0] seed_in4;
  logic       seed_zero_err4, req_ready4, rand_valid4, busy4, period_wrap4;
  logic [7:0] rand_data4, state_out4, step_count4;

  int vectors;
  int miscompares;

  lfsr_rng u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .seed_zero_err (seed_zero_err),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rand_valid    (rand_valid),
    .rand_ready    (rand_ready),
    .rand_data     (rand_data),
    .state_out     (state_out),
    .busy          (busy),
    .period_wrap   (period_wrap),
    .step_count    (step_count)
  );

  lfsr_rng #(.STEPS(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .seed_load     (seed_load4),
    .seed_in       (seed_in4),
    .seed_zero_err (seed_zero_err4),
    .req_valid     (req_valid4),
    .req_ready     (req_ready4),
    .rand_valid    (rand_valid4),
    .rand_ready    (rand_ready4),
    .rand_data     (rand_data4),
    .state_out     (state_out4),
    .busy          (busy4),
    .period_wrap   (period_wrap4),
    .step_count    (step_count4)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the selected instance, then advance to the next falling edge.
  task automatic applyStimulus(input bit sel4, input logic rv, input logic rr,
                               input logic sl, input logic [7:0] si);
    if (sel4) begin
      req_valid4  = rv;
      rand_ready4 = rr;
      seed_load4  = sl;
      seed_in4    = si;
    end else begin
      req_valid  = rv;
      rand_ready = rr;
      seed_load  = sl;
      seed_in    = si;
    end
    @(negedge clk);
  endtask

  // Reference step of the x^8+x^6+x^5+x^4+1 register.
  function automatic logic [7:0] lfsrStep(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0] exp_words [4];
  logic [7:0] model;
  bit         seen [256];

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_words   = '{8'h02, 8'h04, 8'h08, 8'h11};
    rst_n       = 1'b0;
    seed_load   = 1'b0; req_valid  = 1'b0; rand_ready  = 1'b0; seed_in  = 8'h00;
    seed_load4  = 1'b0; req_valid4 = 1'b0; rand_ready4 = 1'b0; seed_in4 = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_state",    32'(state_out),     32'h01);
    checkOutput("rst_valid",    32'(rand_valid),    32'h0);
    checkOutput("rst_ready",    32'(req_ready),     32'h1);
    checkOutput("rst_busy",     32'(busy),          32'h0);
    checkOutput("rst_err",      32'(seed_zero_err), 32'h0);
    checkOutput("rst_wrap",     32'(period_wrap),   32'h0);
    checkOutput("rst_stepcnt",  32'(step_count),    32'h0);
    checkOutput("rst_state4",   32'(state_out4),    32'h01);
    rst_n = 1'b1;
    @(negedge clk);

    // Four requests with the consumer always ready
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_ready_idle", 32'(req_ready), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("t1_valid", 32'(rand_valid), 32'h1);
      checkOutput("t1_data",  32'(rand_data),  32'(exp_words[i]));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("t1_valid_drop", 32'(rand_valid), 32'h0);
    end

    // Backpressure in VALID
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    checkOutput("bp_seed",  32'(state_out),     32'h01);
    checkOutput("bp_noerr", 32'(seed_zero_err), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("bp_valid", 32'(rand_valid), 32'h1);
    checkOutput("bp_data",  32'(rand_data),  32'h02);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("bp_hold_valid", 32'(rand_valid), 32'h1);
      checkOutput("bp_hold_data",  32'(rand_data),  32'h02);
      checkOutput("bp_hold_ready", 32'(req_ready),  32'h0);
      checkOutput("bp_hold_state", 32'(state_out),  32'h02);
    end
    // Release together with a new request: only the return to IDLE happens
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("bp_rel_valid", 32'(rand_valid), 32'h0);
    checkOutput("bp_rel_state", 32'(state_out),  32'h02);
    checkOutput("bp_rel_ready", 32'(req_ready),  32'h1);
    checkOutput("bp_rel_busy",  32'(busy),       32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("bp_next_valid", 32'(rand_valid), 32'h1);
    checkOutput("bp_next_data",  32'(rand_data),  32'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("bp_done", 32'(rand_valid), 32'h0);

    // STEPS=4 latency
    checkOutput("s4_idle_busy", 32'(busy4), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("s4_c1_busy",  32'(busy4),       32'h1);
    checkOutput("s4_c1_valid", 32'(rand_valid4), 32'h0);
    for (int k = 2; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("s4_shift_busy",  32'(busy4),       32'h1);
      checkOutput("s4_shift_valid", 32'(rand_valid4), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("s4_valid", 32'(rand_valid4), 32'h1);
    checkOutput("s4_data",  32'(rand_data4),  32'h11);
    checkOutput("s4_busy",  32'(busy4),       32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("s4_back_idle", 32'(busy4), 32'h0);

    // Zero seed loaded mid-SHIFT, with a competing request
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("zs_shift_busy",  32'(busy4),      32'h1);
    checkOutput("zs_shift_state", 32'(state_out4), 32'h23);
    req_valid4 = 1'b1; rand_ready4 = 1'b0; seed_load4 = 1'b1; seed_in4 = 8'h00;
    #1;
    checkOutput("zs_ready_forced", 32'(req_ready4), 32'h0);
    @(negedge clk);
    checkOutput("zs_state", 32'(state_out4),     32'h01);
    checkOutput("zs_err",   32'(seed_zero_err4), 32'h1);
    checkOutput("zs_valid", 32'(rand_valid4),    32'h0);
    checkOutput("zs_busy",  32'(busy4),          32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("zs_err_once", 32'(seed_zero_err4), 32'h0);
    checkOutput("zs_hold",     32'(state_out4),     32'h01);
    checkOutput("zs_idle",     32'(busy4),          32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
    checkOutput("ld5a_state", 32'(state_out4),     32'h5A);
    checkOutput("ld5a_noerr", 32'(seed_zero_err4), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Full period from seed 0x01
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    checkOutput("per_seed", 32'(state_out), 32'h01);
`ifdef LFSR_PERIOD_MON_EN
    checkOutput("per_cnt_clr", 32'(step_count), 32'h0);
`endif
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    model = 8'h01;
    for (int i = 1; i <= 255; i++) begin
      model = lfsrStep(model);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("per_data",     32'(rand_data),                32'(model));
      checkOutput("per_nonzero",  32'(rand_data == 8'h00),       32'h0);
      checkOutput("per_distinct", 32'(seen[rand_data]),          32'h0);
      seen[rand_data] = 1'b1;
`ifdef LFSR_PERIOD_MON_EN
      checkOutput("per_wrap",    32'(period_wrap), (i == 255) ? 32'h1 : 32'h0);
      checkOutput("per_stepcnt", 32'(step_count),  (i == 255) ? 32'h0 : 32'(i));
`endif
      if (i == 255) begin
        checkOutput("per_last", 32'(rand_data), 32'h01);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    end
    checkOutput("per_wrap_off",    32'(period_wrap), 32'h0);
    checkOutput("per_stepcnt_end", 32'(step_count),  32'h0);

    // Asynchronous reset while in VALID
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("ar_valid_before", 32'(rand_valid), 32'h1);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(rand_valid), 32'h0);
    checkOutput("ar_state", 32'(state_out),  32'h01);
    checkOutput("ar_busy",  32'(busy),       32'h0);
    checkOutput("ar_ready", 32'(req_ready),  32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("ar_first_valid", 32'(rand_valid), 32'h1);
    checkOutput("ar_first_data",  32'(rand_data),  32'h02);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
